// File: rtl/router_in_arbiter.sv
// rtl/router_in_arbiter.sv - packet-level round-robin arbiter feeding the 1x3 router input port
// Optional length/address check enabled by defining ROUTER_ARB_LEN_CHECK_EN.
module router_in_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             src_valid_0,
    input  logic             src_valid_1,
    input  logic             src_valid_2,
    input  logic             src_last_0,
    input  logic             src_last_1,
    input  logic             src_last_2,
    input  logic [WIDTH-1:0] src_data_0,
    input  logic [WIDTH-1:0] src_data_1,
    input  logic [WIDTH-1:0] src_data_2,
    output logic             src_ready_0,
    output logic             src_ready_1,
    output logic             src_ready_2,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [WIDTH-1:0] data_in,
    output logic [2:0]       grant,
    output logic             len_err
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] ptr_q, ptr_d;

    logic [2:0]       valid_v;
    logic [2:0]       last_v;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;
    logic [2:0]       pick;

    assign valid_v = {src_valid_2, src_valid_1, src_valid_0};
    assign last_v  = {src_last_2, src_last_1, src_last_0};

    // grant_q is only non-zero in XFER, so it doubles as the mux select and the idle gate
    assign sel_valid = |(valid_v & grant_q);
    assign sel_last  = |(last_v & grant_q);
    assign sel_data  = ({WIDTH{grant_q[0]}} & src_data_0)
                     | ({WIDTH{grant_q[1]}} & src_data_1)
                     | ({WIDTH{grant_q[2]}} & src_data_2);
    assign xfer      = (state_q == XFER) && sel_valid && !busy;

    assign src_ready_0 = xfer && grant_q[0];
    assign src_ready_1 = xfer && grant_q[1];
    assign src_ready_2 = xfer && grant_q[2];
    assign pkt_valid   = sel_valid && !sel_last;
    assign data_in     = sel_data;
    assign grant       = grant_q;

    // First requester at or after the pointer
    always_comb begin
        pick = 3'b000;
        case (ptr_q)
            2'd1:    pick = valid_v[1] ? 3'b010 : valid_v[2] ? 3'b100 : valid_v[0] ? 3'b001 : 3'b000;
            2'd2:    pick = valid_v[2] ? 3'b100 : valid_v[0] ? 3'b001 : valid_v[1] ? 3'b010 : 3'b000;
            default: pick = valid_v[0] ? 3'b001 : valid_v[1] ? 3'b010 : valid_v[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|valid_v) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer && sel_last) begin
                    state_d = GAP;
                    grant_d = 3'b000;
                    ptr_d   = grant_q[0] ? 2'd1 : grant_q[1] ? 2'd2 : 2'd0;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ROUTER_ARB_LEN_CHECK_EN
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] hdr_len_q;
    logic [1:0] hdr_dst_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && |valid_v) begin
            cnt_d = 7'd0;
        end else if (xfer) begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= 7'd0;
            hdr_len_q <= 6'd0;
            hdr_dst_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (xfer && cnt_q == 7'd0) begin
                hdr_len_q <= sel_data[7:2];
                hdr_dst_q <= sel_data[1:0];
            end
        end
    end

    // Header + payload + parity must match the header length; address 3 has no output port
    assign len_err = (state_q == GAP)
                  && ((cnt_q != ({1'b0, hdr_len_q} + 7'd2)) || (hdr_dst_q == 2'b11));
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_in_arbiter.sv
// tb/tb_router_in_arbiter.sv - self-checking bench for router_in_arbiter
module tb_router_in_arbiter;

    logic       clock;
    logic       reset;
    logic       src_valid_0, src_valid_1, src_valid_2;
    logic       src_last_0, src_last_1, src_last_2;
    logic [7:0] src_data_0, src_data_1, src_data_2;
    logic       src_ready_0, src_ready_1, src_ready_2;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] grant;
    logic       len_err;

    router_in_arbiter #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .src_valid_0 (src_valid_0),
        .src_valid_1 (src_valid_1),
        .src_valid_2 (src_valid_2),
        .src_last_0  (src_last_0),
        .src_last_1  (src_last_1),
        .src_last_2  (src_last_2),
        .src_data_0  (src_data_0),
        .src_data_1  (src_data_1),
        .src_data_2  (src_data_2),
        .src_ready_0 (src_ready_0),
        .src_ready_1 (src_ready_1),
        .src_ready_2 (src_ready_2),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .grant       (grant),
        .len_err     (len_err)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
        logic       err;
    } exp_t;

    typedef struct {
        int         src;
        logic [7:0] hdr;
        int         npay;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] sq0[$];
    logic [8:0] sq1[$];
    logic [8:0] sq2[$];
    exp_t       exp_q[$];
    logic       gap_pending = 1'b0;
    logic       gap_err     = 1'b0;
    vec_t       vecs[7];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input int s);
        logic [2:0] r;
        r = 3'b000;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_len_err(input logic [7:0] hdr, input int npay);
`ifdef ROUTER_ARB_LEN_CHECK_EN
        return (npay != int'(hdr[7:2])) || (hdr[1:0] == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_srcs();
        src_valid_0 = (sq0.size() != 0);
        src_valid_1 = (sq1.size() != 0);
        src_valid_2 = (sq2.size() != 0);
        if (sq0.size() != 0) {src_last_0, src_data_0} = sq0[0];
        else                 {src_last_0, src_data_0} = 9'h0;
        if (sq1.size() != 0) {src_last_1, src_data_1} = sq1[0];
        else                 {src_last_1, src_data_1} = 9'h0;
        if (sq2.size() != 0) {src_last_2, src_data_2} = sq2[0];
        else                 {src_last_2, src_data_2} = 9'h0;
    endtask

    task automatic push_src(input int s, input logic [8:0] b);
        case (s)
            0:       sq0.push_back(b);
            1:       sq1.push_back(b);
            default: sq2.push_back(b);
        endcase
    endtask

    // Queues a packet on source s and pushes its expected bytes in service order
    task automatic send_pkt(input int s, input logic [7:0] hdr, input int npay);
        logic [7:0] par;
        logic [7:0] b;
        logic       err;
        err = exp_len_err(hdr, npay);
        par = hdr;
        push_src(s, {1'b0, hdr});
        exp_q.push_back('{src: s, data: hdr, last: 1'b0, err: err});
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            par ^= b;
            push_src(s, {1'b0, b});
            exp_q.push_back('{src: s, data: b, last: 1'b0, err: err});
        end
        push_src(s, {1'b1, par});
        exp_q.push_back('{src: s, data: par, last: 1'b1, err: err});
        drive_srcs();
    endtask

    task automatic clear_all();
        sq0.delete();
        sq1.delete();
        sq2.delete();
        exp_q.delete();
        gap_pending = 1'b0;
        drive_srcs();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        clear_all();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sq0.size() + sq1.size() + sq2.size() + exp_q.size()) != 0 || gap_pending) begin
            @(negedge clock);
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: %0d bytes left expected 0 after %0d cycles", exp_q.size(), budget);
                clear_all();
                break;
            end
        end
    endtask

    // Source driver: a byte seen ready before the edge is consumed after it
    initial begin
        logic t0, t1, t2;
        forever begin
            @(negedge clock);
            t0 = src_ready_0;
            t1 = src_ready_1;
            t2 = src_ready_2;
            @(posedge clock);
            #1;
            if (!reset) begin
                if (t0 && sq0.size() != 0) void'(sq0.pop_front());
                if (t1 && sq1.size() != 0) void'(sq1.pop_front());
                if (t2 && sq2.size() != 0) void'(sq2.pop_front());
            end
            drive_srcs();
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [2:0] rdy;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                rdy = {src_ready_2, src_ready_1, src_ready_0};
                if (gap_pending) begin
                    check("gap_grant", {29'd0, grant}, 32'd0);
                    check("gap_len_err", {31'd0, len_err}, {31'd0, gap_err});
                    gap_pending = 1'b0;
                end else begin
                    check("len_err_quiet", {31'd0, len_err}, 32'd0);
                end
                if (grant == 3'b000)
                    check("idle_outputs", {20'd0, pkt_valid, data_in, rdy}, 32'd0);
                if (rdy != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", {29'd0, rdy}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_grant", {29'd0, grant}, {29'd0, onehot(e.src)});
                        check("xfer_ready", {29'd0, rdy}, {29'd0, onehot(e.src)});
                        check("xfer_data", {24'd0, data_in}, {24'd0, e.data});
                        check("xfer_pkt_valid", {31'd0, pkt_valid}, {31'd0, !e.last});
                        if (e.last) begin
                            gap_pending = 1'b1;
                            gap_err     = e.err;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{src: 1, hdr: 8'h0E, npay: 3};
        vecs[1] = '{src: 0, hdr: 8'h05, npay: 1};
        vecs[2] = '{src: 2, hdr: 8'h02, npay: 0};
        vecs[3] = '{src: 0, hdr: 8'h08, npay: 3};
        vecs[4] = '{src: 2, hdr: 8'h0B, npay: 2};
        vecs[5] = '{src: 1, hdr: 8'h44, npay: 17};
        vecs[6] = '{src: 1, hdr: 8'h09, npay: 1};

        reset = 1'b1;
        busy  = 1'b0;
        drive_srcs();
        repeat (2) @(negedge clock);
        check("reset_outputs",
              {17'd0, grant, pkt_valid, data_in, src_ready_2, src_ready_1, src_ready_0, len_err}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single-source packets: one arbitration cycle, then grant
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            #1;
            send_pkt(vecs[i].src, vecs[i].hdr, vecs[i].npay);
            @(negedge clock);
            check("arb_cycle_grant", {29'd0, grant}, 32'd0);
            @(negedge clock);
            check("first_grant", {29'd0, grant}, {29'd0, onehot(vecs[i].src)});
            wait_drain(200);
        end

        // Simultaneous requests after reset: order 0,1,2
        do_reset();
        send_pkt(0, 8'h0C, 3);
        send_pkt(1, 8'h09, 2);
        send_pkt(2, 8'h06, 1);
        wait_drain(400);

        // Fairness between 0 and 2: 0,2,0,2
        do_reset();
        send_pkt(0, 8'h04, 1);
        send_pkt(2, 8'h08, 2);
        send_pkt(0, 8'h0D, 3);
        send_pkt(2, 8'h01, 0);
        wait_drain(400);

        // Mid-payload stall on source 1
        @(posedge clock);
        #1;
        send_pkt(1, 8'h10, 4);
        repeat (3) @(posedge clock);
        #1 busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall_ready", {31'd0, src_ready_1}, 32'd0);
            check("stall_grant", {29'd0, grant}, 32'd2);
            check("stall_data", {24'd0, data_in}, {24'd0, exp_q[0].data});
            check("stall_pkt_valid", {31'd0, pkt_valid}, 32'd1);
        end
        @(posedge clock);
        #1 busy = 1'b0;
        wait_drain(200);

        // Asynchronous reset mid-packet of source 2; pointer must return to 0
        @(posedge clock);
        #1;
        send_pkt(2, 8'h14, 5);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("pre_reset_grant", {29'd0, grant}, 32'd4);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {17'd0, grant, pkt_valid, data_in, src_ready_2, src_ready_1, src_ready_0, len_err}, 32'd0);
        clear_all();
        @(posedge clock);
        #1 reset = 1'b0;
        send_pkt(0, 8'h08, 2);
        send_pkt(2, 8'h05, 1);
        wait_drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
